// File: rtl/multicycle_ctrl_pkg.sv
// rtl/multicycle_ctrl_pkg.sv - state encoding, opcodes and select encodings for multicycle_ctrl
package multicycle_ctrl_pkg;

   typedef enum logic [3:0] {
      S_FETCH   = 4'd0,
      S_DECODE  = 4'd1,
      S_MEMADR  = 4'd2,
      S_MEMRD   = 4'd3,
      S_MEMWB   = 4'd4,
      S_MEMWR   = 4'd5,
      S_RTYPEEX = 4'd6,
      S_ALUWB   = 4'd7,
      S_BEQEX   = 4'd8,
      S_ADDIEX  = 4'd9,
      S_ADDIWB  = 4'd10,
      S_JEX     = 4'd11,
      S_TRAP    = 4'd12
   } state_t;

   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_J     = 6'b000010;

   localparam logic [1:0] ALUSRCB_REGB  = 2'b00;
   localparam logic [1:0] ALUSRCB_FOUR  = 2'b01;
   localparam logic [1:0] ALUSRCB_IMM   = 2'b10;
   localparam logic [1:0] ALUSRCB_IMMSH = 2'b11;

   localparam logic [1:0] PCSRC_ALURES = 2'b00;
   localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
   localparam logic [1:0] PCSRC_JUMP   = 2'b10;

   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;

   function automatic state_t decode_next(input logic [5:0] op);
      case (op)
         OP_LW, OP_SW: return S_MEMADR;
         OP_RTYPE:     return S_RTYPEEX;
         OP_BEQ:       return S_BEQEX;
         OP_ADDI:      return S_ADDIEX;
         OP_J:         return S_JEX;
         default:      return S_TRAP;
      endcase
   endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// rtl/multicycle_ctrl_if.sv - controller <-> datapath/memory signal bundle
interface multicycle_ctrl_if;
   logic [5:0] op;
   logic       zero;
   logic       mem_ready;
   logic       mem_req;
   logic       mem_we;
   logic       iord;
   logic       irwrite;
   logic       pc_en;
   logic [1:0] pcsrc;
   logic       alusrca;
   logic [1:0] alusrcb;
   logic [1:0] aluop;
   logic       regdst;
   logic       memtoreg;
   logic       regwrite;
   logic       trap;

   modport master (
      input  op, zero, mem_ready,
      output mem_req, mem_we, iord, irwrite, pc_en, pcsrc, alusrca, alusrcb,
             aluop, regdst, memtoreg, regwrite, trap
   );

   modport slave (
      output op, zero, mem_ready,
      input  mem_req, mem_we, iord, irwrite, pc_en, pcsrc, alusrca, alusrcb,
             aluop, regdst, memtoreg, regwrite, trap
   );
endinterface

// File: rtl/multicycle_ctrl_perf.sv
// rtl/multicycle_ctrl_perf.sv - free-running cycle and retired-instruction counters
module multicycle_ctrl_perf #(
   parameter int CNT_WIDTH = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 retire,
   output logic [CNT_WIDTH-1:0] cycle_cnt,
   output logic [CNT_WIDTH-1:0] instr_cnt
);
   logic [CNT_WIDTH-1:0] cycle_q, cycle_d;
   logic [CNT_WIDTH-1:0] instr_q, instr_d;

   always_comb begin
      cycle_d = cycle_q + CNT_WIDTH'(1);
      instr_d = instr_q + CNT_WIDTH'(retire);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cycle_q <= '0;
         instr_q <= '0;
      end else begin
         cycle_q <= cycle_d;
         instr_q <= instr_d;
      end
   end

   assign cycle_cnt = cycle_q;
   assign instr_cnt = instr_q;
endmodule

// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - multi-cycle MIPS control FSM; MULTICYCLE_CTRL_PERF_EN adds perf counters
module multicycle_ctrl
   import multicycle_ctrl_pkg::*;
#(
   parameter int CNT_WIDTH   = 32,
   parameter int MEM_TIMEOUT = 0
) (
   input  logic                 clk,
   input  logic                 rst,
   multicycle_ctrl_if.master    bus,
   output logic [CNT_WIDTH-1:0] cycle_cnt,
   output logic [CNT_WIDTH-1:0] instr_cnt
);
   localparam int TW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
   localparam logic [TW-1:0] WAIT_LAST = TW'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

   state_t          state_q, state_d;
   logic [TW-1:0]   wait_q, wait_d;
   logic            trap_q, trap_d;

   logic       mem_req_s, mem_we_s, iord_s, irwrite_s, pc_en_s;
   logic [1:0] pcsrc_s, alusrcb_s, aluop_s;
   logic       alusrca_s, regdst_s, memtoreg_s, regwrite_s;
   logic       mem_stall, timeout;

   always_comb begin
      mem_req_s  = 1'b0;
      mem_we_s   = 1'b0;
      iord_s     = 1'b0;
      irwrite_s  = 1'b0;
      pc_en_s    = 1'b0;
      pcsrc_s    = PCSRC_ALURES;
      alusrca_s  = 1'b0;
      alusrcb_s  = ALUSRCB_REGB;
      aluop_s    = ALUOP_ADD;
      regdst_s   = 1'b0;
      memtoreg_s = 1'b0;
      regwrite_s = 1'b0;
      case (state_q)
         S_FETCH: begin
            mem_req_s = 1'b1;
            alusrcb_s = ALUSRCB_FOUR;
            irwrite_s = bus.mem_ready;
            pc_en_s   = bus.mem_ready;
         end
         S_DECODE:  alusrcb_s = ALUSRCB_IMMSH;
         S_MEMADR: begin
            alusrca_s = 1'b1;
            alusrcb_s = ALUSRCB_IMM;
         end
         S_MEMRD: begin
            mem_req_s = 1'b1;
            iord_s    = 1'b1;
         end
         S_MEMWB: begin
            regwrite_s = 1'b1;
            memtoreg_s = 1'b1;
         end
         S_MEMWR: begin
            mem_req_s = 1'b1;
            mem_we_s  = 1'b1;
            iord_s    = 1'b1;
         end
         S_RTYPEEX: begin
            alusrca_s = 1'b1;
            aluop_s   = ALUOP_FUNCT;
         end
         S_ALUWB: begin
            regwrite_s = 1'b1;
            regdst_s   = 1'b1;
         end
         S_BEQEX: begin
            alusrca_s = 1'b1;
            aluop_s   = ALUOP_SUB;
            pcsrc_s   = PCSRC_ALUOUT;
            pc_en_s   = bus.zero;
         end
         S_ADDIEX: begin
            alusrca_s = 1'b1;
            alusrcb_s = ALUSRCB_IMM;
         end
         S_ADDIWB:  regwrite_s = 1'b1;
         S_JEX: begin
            pcsrc_s = PCSRC_JUMP;
            pc_en_s = 1'b1;
         end
         default: ;
      endcase
   end

   // mem_ready on the last allowed wait cycle still advances normally
   assign mem_stall = mem_req_s & ~bus.mem_ready;
   assign timeout   = (MEM_TIMEOUT > 0) && mem_stall && (wait_q == WAIT_LAST);

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_FETCH:   if (bus.mem_ready) state_d = S_DECODE;
         S_DECODE:  state_d = decode_next(bus.op);
         S_MEMADR:  state_d = (bus.op == OP_LW) ? S_MEMRD : S_MEMWR;
         S_MEMRD:   if (bus.mem_ready) state_d = S_MEMWB;
         S_MEMWB:   state_d = S_FETCH;
         S_MEMWR:   if (bus.mem_ready) state_d = S_FETCH;
         S_RTYPEEX: state_d = S_ALUWB;
         S_ALUWB:   state_d = S_FETCH;
         S_BEQEX:   state_d = S_FETCH;
         S_ADDIEX:  state_d = S_ADDIWB;
         S_ADDIWB:  state_d = S_FETCH;
         S_JEX:     state_d = S_FETCH;
         default:   state_d = S_TRAP;
      endcase
      if (timeout) state_d = S_TRAP;
      trap_d = trap_q | (state_d == S_TRAP);
      wait_d = (state_d != state_q) ? '0 : (mem_stall ? wait_q + TW'(1) : wait_q);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_FETCH;
         wait_q  <= '0;
         trap_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         wait_q  <= wait_d;
         trap_q  <= trap_d;
      end
   end

   assign bus.mem_req  = mem_req_s  & ~rst;
   assign bus.mem_we   = mem_we_s   & ~rst;
   assign bus.iord     = iord_s     & ~rst;
   assign bus.irwrite  = irwrite_s  & ~rst;
   assign bus.pc_en    = pc_en_s    & ~rst;
   assign bus.pcsrc    = rst ? 2'b00 : pcsrc_s;
   assign bus.alusrca  = alusrca_s  & ~rst;
   assign bus.alusrcb  = rst ? 2'b00 : alusrcb_s;
   assign bus.aluop    = rst ? 2'b00 : aluop_s;
   assign bus.regdst   = regdst_s   & ~rst;
   assign bus.memtoreg = memtoreg_s & ~rst;
   assign bus.regwrite = regwrite_s & ~rst;
   assign bus.trap     = trap_q;

`ifdef MULTICYCLE_CTRL_PERF_EN
   logic retire;
   // every instruction ends by returning to FETCH; TRAP never does
   assign retire = (state_d == S_FETCH) && (state_q != S_FETCH);

   multicycle_ctrl_perf #(
      .CNT_WIDTH (CNT_WIDTH)
   ) u_perf (
      .clk       (clk),
      .rst       (rst),
      .retire    (retire),
      .cycle_cnt (cycle_cnt),
      .instr_cnt (instr_cnt)
   );
`else
   assign cycle_cnt = '0;
   assign instr_cnt = '0;
`endif
endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb/tb_multicycle_ctrl.sv - scoreboard bench for multicycle_ctrl
module tb_multicycle_ctrl;
   logic clk = 1'b0;
   logic rst;
   logic [31:0] cycle_cnt, instr_cnt;

   always #5 clk = ~clk;

   multicycle_ctrl_if bus();

   multicycle_ctrl #(
      .CNT_WIDTH   (32),
      .MEM_TIMEOUT (4)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .bus       (bus),
      .cycle_cnt (cycle_cnt),
      .instr_cnt (instr_cnt)
   );

`ifdef MULTICYCLE_CTRL_PERF_EN
   localparam bit PERF = 1'b1;
`else
   localparam bit PERF = 1'b0;
`endif

   typedef struct packed {
      logic [15:0] v;
      logic [31:0] cyc;
      logic [31:0] ins;
   } exp_t;

   exp_t        sb_q[$];
   exp_t        mon_e;
   int          n_cmp = 0;
   int          n_bad = 0;
   bit          mon_en = 1'b0;
   logic [31:0] m_cyc, m_ins;
   logic [15:0] act;

   // {mem_req, mem_we, iord, irwrite, pc_en, pcsrc, alusrca, alusrcb, aluop, regdst, memtoreg, regwrite, trap}
   function automatic logic [15:0] mk(input logic mreq, input logic mwe, input logic io,
                                      input logic irw, input logic pce, input logic [1:0] psrc,
                                      input logic asa, input logic [1:0] asb, input logic [1:0] aop,
                                      input logic rd, input logic m2r, input logic rw, input logic tr);
      return {mreq, mwe, io, irw, pce, psrc, asa, asb, aop, rd, m2r, rw, tr};
   endfunction

   function automatic logic [15:0] v_fetch(input logic r);
      return mk(1, 0, 0, r, r, 2'b00, 0, 2'b01, 2'b00, 0, 0, 0, 0);
   endfunction
   function automatic logic [15:0] v_beq(input logic z);
      return mk(0, 0, 0, 0, z, 2'b01, 1, 2'b00, 2'b01, 0, 0, 0, 0);
   endfunction
   function automatic logic [15:0] v_rst(input logic t);
      return mk(0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 2'b00, 0, 0, 0, t);
   endfunction

   localparam logic [15:0] V_DEC    = 16'b0_0_0_0_0_00_0_11_00_0_0_0_0;
   localparam logic [15:0] V_MEMADR = 16'b0_0_0_0_0_00_1_10_00_0_0_0_0;
   localparam logic [15:0] V_MEMRD  = 16'b1_0_1_0_0_00_0_00_00_0_0_0_0;
   localparam logic [15:0] V_MEMWB  = 16'b0_0_0_0_0_00_0_00_00_0_1_1_0;
   localparam logic [15:0] V_MEMWR  = 16'b1_1_1_0_0_00_0_00_00_0_0_0_0;
   localparam logic [15:0] V_RTEX   = 16'b0_0_0_0_0_00_1_00_10_0_0_0_0;
   localparam logic [15:0] V_ALUWB  = 16'b0_0_0_0_0_00_0_00_00_1_0_1_0;
   localparam logic [15:0] V_ADDIEX = 16'b0_0_0_0_0_00_1_10_00_0_0_0_0;
   localparam logic [15:0] V_ADDIWB = 16'b0_0_0_0_0_00_0_00_00_0_0_1_0;
   localparam logic [15:0] V_J      = 16'b0_0_0_0_1_10_0_00_00_0_0_0_0;
   localparam logic [15:0] V_TRAP   = 16'b0_0_0_0_0_00_0_00_00_0_0_0_1;

   localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000;
   localparam logic [5:0] BEQ = 6'b000100, ADDI = 6'b001000, JMP = 6'b000010;

   function automatic logic [5:0] op_of(input int k);
      case (k)
         0: return LW;
         1: return SW;
         2: return RT;
         3: return BEQ;
         4: return ADDI;
         default: return JMP;
      endcase
   endfunction

   function automatic bit is_legal(input logic [5:0] o);
      return (o == LW) || (o == SW) || (o == RT) || (o == BEQ) || (o == ADDI) || (o == JMP);
   endfunction

   function automatic logic rb();
      return 1'($urandom_range(0, 1));
   endfunction

   // one clock cycle: drive inputs, record what the outputs must be during it
   task automatic step(input logic r, input logic rdy, input logic [15:0] v, input bit retire);
      exp_t e;
      rst = r;
      bus.mem_ready = rdy;
      e.v   = v;
      e.cyc = PERF ? m_cyc : 32'd0;
      e.ins = PERF ? m_ins : 32'd0;
      sb_q.push_back(e);
      if (r) begin
         m_cyc = 32'd0;
         m_ins = 32'd0;
      end else begin
         m_cyc = m_cyc + 32'd1;
         if (retire) m_ins = m_ins + 32'd1;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset(input int n, input logic t);
      for (int i = 0; i < n; i++) step(1'b1, rb(), v_rst((i == 0) ? t : 1'b0), 1'b0);
   endtask

   task automatic fetch_dec(input logic [5:0] o, input logic z, input int wf);
      bus.op = o;
      bus.zero = z;
      for (int i = 0; i <= wf; i++) step(1'b0, (i == wf), v_fetch(i == wf), 1'b0);
      step(1'b0, rb(), V_DEC, 1'b0);
   endtask

   task automatic instr(input logic [5:0] o, input logic z, input int wf, input int wm);
      fetch_dec(o, z, wf);
      case (o)
         LW: begin
            step(1'b0, rb(), V_MEMADR, 1'b0);
            for (int i = 0; i <= wm; i++) step(1'b0, (i == wm), V_MEMRD, 1'b0);
            step(1'b0, rb(), V_MEMWB, 1'b1);
         end
         SW: begin
            step(1'b0, rb(), V_MEMADR, 1'b0);
            for (int i = 0; i <= wm; i++) step(1'b0, (i == wm), V_MEMWR, (i == wm));
         end
         RT: begin
            step(1'b0, rb(), V_RTEX, 1'b0);
            step(1'b0, rb(), V_ALUWB, 1'b1);
         end
         BEQ:  step(1'b0, rb(), v_beq(z), 1'b1);
         ADDI: begin
            step(1'b0, rb(), V_ADDIEX, 1'b0);
            step(1'b0, rb(), V_ADDIWB, 1'b1);
         end
         JMP:  step(1'b0, rb(), V_J, 1'b1);
         default: for (int i = 0; i < 3; i++) step(1'b0, rb(), V_TRAP, 1'b0);
      endcase
   endtask

   always @(negedge clk) begin
      if (mon_en) begin
         act = {bus.mem_req, bus.mem_we, bus.iord, bus.irwrite, bus.pc_en, bus.pcsrc,
                bus.alusrca, bus.alusrcb, bus.aluop, bus.regdst, bus.memtoreg,
                bus.regwrite, bus.trap};
         if (sb_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL scoreboard_underflow at %0t: no expectation queued", $time);
         end else begin
            mon_e = sb_q.pop_front();
            n_cmp++;
            if (act !== mon_e.v) begin
               n_bad++;
               $display("FAIL ctrl_vec at %0t: got %b expected %b", $time, act, mon_e.v);
            end
            n_cmp++;
            if (cycle_cnt !== mon_e.cyc) begin
               n_bad++;
               $display("FAIL cycle_cnt at %0t: got %0d expected %0d", $time, cycle_cnt, mon_e.cyc);
            end
            n_cmp++;
            if (instr_cnt !== mon_e.ins) begin
               n_bad++;
               $display("FAIL instr_cnt at %0t: got %0d expected %0d", $time, instr_cnt, mon_e.ins);
            end
         end
      end
   end

   initial begin
      logic [5:0] o;
      rst = 1'b1;
      bus.op = 6'd0;
      bus.zero = 1'b0;
      bus.mem_ready = 1'b0;
      m_cyc = 32'd0;
      m_ins = 32'd0;
      repeat (2) @(posedge clk);
      #1;
      mon_en = 1'b1;

      instr(LW, 1'b0, 0, 0);
      instr(BEQ, 1'b1, 0, 0);
      instr(BEQ, 1'b0, 0, 0);
      instr(RT, 1'b0, 3, 0);

      for (int n = 0; n < 40; n++)
         instr(op_of($urandom_range(0, 5)), rb(), $urandom_range(0, 3), $urandom_range(0, 3));

      instr(6'b111111, 1'b0, 0, 0);
      do_reset(1, 1'b1);
      instr(ADDI, 1'b0, 0, 0);

      // load whose memory never answers: four wait cycles then TRAP
      fetch_dec(LW, 1'b0, 0);
      step(1'b0, rb(), V_MEMADR, 1'b0);
      for (int i = 0; i < 4; i++) step(1'b0, 1'b0, V_MEMRD, 1'b0);
      step(1'b0, rb(), V_TRAP, 1'b0);
      step(1'b0, rb(), V_TRAP, 1'b0);
      do_reset(1, 1'b1);
      instr(LW, 1'b0, 0, 3);
      instr(SW, 1'b0, 3, 3);

      do_reset(1, 1'b0);
      instr(RT, 1'b0, 0, 0);
      instr(ADDI, 1'b0, 1, 0);
      instr(SW, 1'b0, 0, 1);
      instr(JMP, 1'b0, 0, 0);
      fetch_dec(SW, 1'b0, 0);
      step(1'b0, rb(), V_MEMADR, 1'b0);
      step(1'b0, 1'b0, V_MEMWR, 1'b0);
      do_reset(1, 1'b0);
      instr(JMP, 1'b0, 0, 0);

      for (int n = 0; n < 3; n++) begin
         o = 6'($urandom_range(0, 63));
         while (is_legal(o)) o = 6'($urandom_range(0, 63));
         instr(o, rb(), $urandom_range(0, 2), 0);
         do_reset(2, 1'b1);
         instr(op_of($urandom_range(0, 5)), rb(), 0, 0);
      end

      mon_en = 1'b0;
      n_cmp++;
      if (sb_q.size() != 0) begin
         n_bad++;
         $display("FAIL scoreboard_drain: %0d expectations left, expected 0", sb_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
